stage_two_decode: RTL and testbench
===================================

# stage_two_decode

Instruction-decode stage of the MUSA pipeline, directly downstream of the instruction-fetch stage. It captures the fetched PC and instruction in the IF/ID pipeline register, splits the instruction into fields, reads operands from a 32×32 register file that it owns, and sign-extends the immediate. It also detects load-use hazards, stalling the fetch stage and injecting a bubble toward the ID/EX register. Taken branches flush it.

## Interface
Parameters:
- none; widths are fixed: 13-bit PC, 32-bit instruction and data, 32 registers.

Ports:
- _clk  in  1  system clock; all state updates on the rising edge.
- _reset  in  1  asynchronous, active-low reset.
- _pcIn  in  13  PC of the fetched instruction, from the fetch stage.
- _instructionIn  in  32  fetched instruction, from the fetch stage.
- _flush  in  1  taken branch/jump from EX; discards the instruction held in IF/ID.
- _exMemRead  in  1  instruction currently in ID/EX is a load.
- _exRt  in  5  destination register of the instruction in ID/EX.
- _wbWrite  in  1  write-back enable.
- _wbAddr  in  5  write-back register index.
- _wbData  in  32  write-back data.
- _pcWrite  out  1  fetch-stage PC enable; 0 during a stall.
- _pcOut  out  13  latched PC.
- _opcode  out  6  instr[31:26].
- _rs, _rt, _rd  out  5 each  instr[25:21], [20:16], [15:11].
- _rsData, _rtData  out  32  operand values.
- _immExt  out  32  sign-extended instr[15:0].
- _bubble  out  1  tells ID/EX to load a NOP instead of the decode outputs.

## Operation
- **IF/ID register.** Holds pc (13), instr (32) and valid (1).
  - Async reset: pc=0, instr=0 (NOP), valid=0.
  - At each edge, apply the first matching rule, in this priority:
    1. _flush=1: instr←0, valid←0, pc←_pcIn.
    2. stall=1: hold all three fields.
    3. otherwise: pc←_pcIn, instr←_instructionIn, valid←1.
- **Register file.** 32 entries of 32 bits.
  - Async reset clears every entry to 0.
  - Write at the edge when _wbWrite=1 and _wbAddr≠0. Register r0 is never written.
  - Reads are combinational from instr.
  - Read of r0 always returns 0.
  - Write-through bypass: if _wbWrite=1, _wbAddr≠0 and _wbAddr equals the read index, the read returns _wbData in the same cycle.
- **Decode.** Field outputs are pure slices of the latched instr. _immExt = {16{instr[15]}, instr[15:0]}. _pcOut = latched pc.
- **Hazard detection.** stall = valid & _exMemRead & (_exRt≠0) & (_exRt==rs | _exRt==rt).
  - The check is conservative: rt is always compared, whatever the opcode.
  - _pcWrite = ~stall.
  - _bubble = stall | ~valid.
- **Flush and stall together.** Flush wins: IF/ID becomes an invalid NOP. _pcWrite still follows that cycle's stall term, so the fetch stage must give its branch redirect priority over _pcWrite.

## Timing
- Latency: an instruction presented on _instructionIn before edge N drives the decode outputs after edge N (1 cycle).
- Stall length: exactly one cycle per load-use pair. After the following edge the load has advanced out of ID/EX, so stall clears.
- Write-back to the same register being read: the value is visible in the same cycle through the bypass and is stored at the edge.
- Reset values, driven asynchronously while _reset=0 (regardless of the clock):
  - _pcOut=0, _opcode=0, _rs=_rt=_rd=0, _rsData=_rtData=0, _immExt=0.
  - _bubble=1, _pcWrite=1.
- Reset asserted mid-stall or mid-flush: all state clears immediately; the first edge after release loads a fresh instruction.
- No other wrap-around or width cases: no arithmetic apart from sign extension.

## Test plan
- **Reset:** assert _reset=0 mid-cycle with nonzero state.
  - -> all outputs at reset values immediately; _bubble=1, _pcWrite=1.
- **Basic decode:** _pcIn=13'h004, _instructionIn=32'h8C22FFFC, no hazard.
  - -> after one edge: _opcode=6'h23, _rs=1, _rt=2, _immExt=32'hFFFFFFFC, _pcOut=4, _bubble=0.
- **Write-back and bypass:**
  - write r5=32'hDEADBEEF, then decode an instruction with rs=5 -> _rsData=32'hDEADBEEF.
  - write to r5 in the same cycle as the read -> bypassed value seen.
  - write to r0 -> r0 still reads 0.
- **Load-use stall:** _exMemRead=1, _exRt=3, latched rs=3.
  - -> _pcWrite=0, _bubble=1, IF/ID holds across the edge.
  - with _exMemRead=0 on the next cycle -> stall clears; the same instruction is decoded with _bubble=0.
- **No false stall:** _exRt=0 with _exMemRead=1 and rs=0 -> _pcWrite=1, _bubble=0.
- **Flush during stall:** stall condition active and _flush=1.
  - -> after the edge: instr=0, valid=0, _bubble=1.
  - the next non-flushed edge loads _instructionIn normally.

Source files
------------

// File: rtl/stage_two_decode.sv
// MUSA pipeline instruction-decode stage.
// Holds the IF/ID pipeline register and owns the 32x32 register file.
// Splits the latched instruction into fields and sign-extends the immediate.
// Detects load-use hazards: stalls fetch and asks ID/EX to load a bubble.
module stage_two_decode (
  input  logic        _clk,
  input  logic        _reset,
  input  logic [12:0] _pcIn,
  input  logic [31:0] _instructionIn,
  input  logic        _flush,
  input  logic        _exMemRead,
  input  logic [4:0]  _exRt,
  input  logic        _wbWrite,
  input  logic [4:0]  _wbAddr,
  input  logic [31:0] _wbData,
  output logic        _pcWrite,
  output logic [12:0] _pcOut,
  output logic [5:0]  _opcode,
  output logic [4:0]  _rs,
  output logic [4:0]  _rt,
  output logic [4:0]  _rd,
  output logic [31:0] _rsData,
  output logic [31:0] _rtData,
  output logic [31:0] _immExt,
  output logic        _bubble
);

  logic [12:0] pc_r;
  logic [31:0] instr_r;
  logic        valid_r;
  logic [31:0] regs_r [32];

  logic        stall_s;
  logic        wb_en_s;
  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic [31:0] rs_data_s;
  logic [31:0] rt_data_s;

  assign rs_s    = instr_r[25:21];
  assign rt_s    = instr_r[20:16];
  assign wb_en_s = _wbWrite && (_wbAddr != 5'd0);

  // Load-use hazard: rt is compared even when the opcode does not read it.
  assign stall_s = valid_r && _exMemRead && (_exRt != 5'd0) &&
                   ((_exRt == rs_s) || (_exRt == rt_s));

  // IF/ID register: flush beats stall, stall beats a normal load.
  always_ff @(posedge _clk or negedge _reset) begin
    if (!_reset) begin
      pc_r    <= 13'd0;
      instr_r <= 32'd0;
      valid_r <= 1'b0;
    end else if (_flush) begin
      pc_r    <= _pcIn;
      instr_r <= 32'd0;
      valid_r <= 1'b0;
    end else if (stall_s) begin
      pc_r    <= pc_r;
      instr_r <= instr_r;
      valid_r <= valid_r;
    end else begin
      pc_r    <= _pcIn;
      instr_r <= _instructionIn;
      valid_r <= 1'b1;
    end
  end

  // Register file write port; r0 is never written.
  always_ff @(posedge _clk or negedge _reset) begin
    if (!_reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (wb_en_s) begin
      regs_r[_wbAddr] <= _wbData;
    end else begin
      regs_r[_wbAddr] <= regs_r[_wbAddr];
    end
  end

  // Operand reads: r0 is hard zero, a same-cycle write-back is forwarded.
  always_comb begin
    rs_data_s = 32'd0;
    rt_data_s = 32'd0;
    if (rs_s == 5'd0) begin
      rs_data_s = 32'd0;
    end else if (wb_en_s && (_wbAddr == rs_s)) begin
      rs_data_s = _wbData;
    end else begin
      rs_data_s = regs_r[rs_s];
    end
    if (rt_s == 5'd0) begin
      rt_data_s = 32'd0;
    end else if (wb_en_s && (_wbAddr == rt_s)) begin
      rt_data_s = _wbData;
    end else begin
      rt_data_s = regs_r[rt_s];
    end
  end

  assign _pcOut   = pc_r;
  assign _opcode  = instr_r[31:26];
  assign _rs      = rs_s;
  assign _rt      = rt_s;
  assign _rd      = instr_r[15:11];
  assign _rsData  = rs_data_s;
  assign _rtData  = rt_data_s;
  assign _immExt  = {{16{instr_r[15]}}, instr_r[15:0]};
  assign _pcWrite = ~stall_s;
  assign _bubble  = stall_s | ~valid_r;

endmodule

// File: tb/tb_stage_two_decode.sv
// Directed, table-driven bench for stage_two_decode.
module tb_stage_two_decode;

  logic        clk;
  logic        rst_n;
  logic [12:0] pc_in;
  logic [31:0] instr_in;
  logic        flush;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        wb_write;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        pc_write;
  logic [12:0] pc_out;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rs_data, rt_data, imm_ext;
  logic        bubble;

  int passed;
  int total;

  typedef struct {
    logic [12:0] pc_in;
    logic [31:0] instr_in;
    logic        flush;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        wb_write;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [12:0] e_pc;
    logic [5:0]  e_op;
    logic [4:0]  e_rs;
    logic [4:0]  e_rt;
    logic [4:0]  e_rd;
    logic [31:0] e_rsd;
    logic [31:0] e_rtd;
    logic [31:0] e_imm;
    logic        e_bubble;
    logic        e_pcw;
  } vec_t;

  vec_t vecs [9];

  stage_two_decode dut (
    ._clk(clk),
    ._reset(rst_n),
    ._pcIn(pc_in),
    ._instructionIn(instr_in),
    ._flush(flush),
    ._exMemRead(ex_mem_read),
    ._exRt(ex_rt),
    ._wbWrite(wb_write),
    ._wbAddr(wb_addr),
    ._wbData(wb_data),
    ._pcWrite(pc_write),
    ._pcOut(pc_out),
    ._opcode(opcode),
    ._rs(rs),
    ._rt(rt),
    ._rd(rd),
    ._rsData(rs_data),
    ._rtData(rt_data),
    ._immExt(imm_ext),
    ._bubble(bubble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s (step %0d): got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input vec_t v);
    chk("pcOut",   idx, 32'(pc_out),   32'(v.e_pc));
    chk("opcode",  idx, 32'(opcode),   32'(v.e_op));
    chk("rs",      idx, 32'(rs),       32'(v.e_rs));
    chk("rt",      idx, 32'(rt),       32'(v.e_rt));
    chk("rd",      idx, 32'(rd),       32'(v.e_rd));
    chk("rsData",  idx, rs_data,       v.e_rsd);
    chk("rtData",  idx, rt_data,       v.e_rtd);
    chk("immExt",  idx, imm_ext,       v.e_imm);
    chk("bubble",  idx, 32'(bubble),   32'(v.e_bubble));
    chk("pcWrite", idx, 32'(pc_write), 32'(v.e_pcw));
  endtask

  initial begin
    passed = 0;
    total  = 0;

    // Inputs are applied after a negedge; expected outputs are for the state
    // latched at the previous posedge combined with these inputs.
    //          pcIn      instrIn       fl   mr   exRt  wbW  wbA   wbData
    //          ePc       eOp    eRs   eRt   eRd    eRsD          eRtD          eImm          eBub eP
    vecs[0] = '{13'h004, 32'h8C22FFFC, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
                13'h000, 6'h00, 5'd0, 5'd0, 5'd0,  32'h0,        32'h0,        32'h0,        1'b1, 1'b1};
    vecs[1] = '{13'h008, 32'h00A63820, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF,
                13'h004, 6'h23, 5'd1, 5'd2, 5'd31, 32'h0,        32'h0,        32'hFFFFFFFC, 1'b0, 1'b1};
    vecs[2] = '{13'h00C, 32'h8C648000, 1'b0, 1'b0, 5'd0, 1'b1, 5'd6, 32'h12345678,
                13'h008, 6'h00, 5'd5, 5'd6, 5'd7,  32'hDEADBEEF, 32'h12345678, 32'h00003820, 1'b0, 1'b1};
    vecs[3] = '{13'h010, 32'hFFFFFFFF, 1'b0, 1'b1, 5'd3, 1'b1, 5'd0, 32'hFFFFFFFF,
                13'h00C, 6'h23, 5'd3, 5'd4, 5'd16, 32'h0,        32'h0,        32'hFFFF8000, 1'b1, 1'b0};
    vecs[4] = '{13'h014, 32'h00060000, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
                13'h00C, 6'h23, 5'd3, 5'd4, 5'd16, 32'h0,        32'h0,        32'hFFFF8000, 1'b0, 1'b1};
    vecs[5] = '{13'h018, 32'h8C22FFFC, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0,
                13'h014, 6'h00, 5'd0, 5'd6, 5'd0,  32'h0,        32'h12345678, 32'h0,        1'b0, 1'b1};
    vecs[6] = '{13'h01C, 32'h00A63820, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 32'h0,
                13'h018, 6'h23, 5'd1, 5'd2, 5'd31, 32'h0,        32'h0,        32'hFFFFFFFC, 1'b1, 1'b0};
    vecs[7] = '{13'h020, 32'h00A63820, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0,
                13'h01C, 6'h00, 5'd0, 5'd0, 5'd0,  32'h0,        32'h0,        32'h0,        1'b1, 1'b1};
    vecs[8] = '{13'h024, 32'h00A63820, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hCAFEF00D,
                13'h020, 6'h00, 5'd5, 5'd6, 5'd7,  32'hCAFEF00D, 32'h12345678, 32'h00003820, 1'b0, 1'b1};

    rst_n       = 1'b0;
    pc_in       = 13'd0;
    instr_in    = 32'd0;
    flush       = 1'b0;
    ex_mem_read = 1'b0;
    ex_rt       = 5'd0;
    wb_write    = 1'b0;
    wb_addr     = 5'd0;
    wb_data     = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      if (i != 0) @(negedge clk);
      pc_in       = vecs[i].pc_in;
      instr_in    = vecs[i].instr_in;
      flush       = vecs[i].flush;
      ex_mem_read = vecs[i].ex_mem_read;
      ex_rt       = vecs[i].ex_rt;
      wb_write    = vecs[i].wb_write;
      wb_addr     = vecs[i].wb_addr;
      wb_data     = vecs[i].wb_data;
      #1;
      chk_all(i, vecs[i]);
    end

    // Reset asserted mid-cycle while a load-use stall is active.
    @(negedge clk);
    pc_in       = 13'h028;
    instr_in    = 32'h8C22FFFC;
    wb_write    = 1'b0;
    wb_addr     = 5'd0;
    wb_data     = 32'd0;
    ex_mem_read = 1'b1;
    ex_rt       = 5'd5;
    #1;
    chk("pre_rst_pcWrite", 9, 32'(pc_write), 32'd0);
    chk("pre_rst_rsData",  9, rs_data, 32'hCAFEF00D);
    chk("pre_rst_pcOut",   9, 32'(pc_out), 32'h024);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_pcOut",   10, 32'(pc_out),   32'd0);
    chk("rst_opcode",  10, 32'(opcode),   32'd0);
    chk("rst_rs",      10, 32'(rs),       32'd0);
    chk("rst_rt",      10, 32'(rt),       32'd0);
    chk("rst_rd",      10, 32'(rd),       32'd0);
    chk("rst_rsData",  10, rs_data,       32'd0);
    chk("rst_rtData",  10, rt_data,       32'd0);
    chk("rst_immExt",  10, imm_ext,       32'd0);
    chk("rst_bubble",  10, 32'(bubble),   32'd1);
    chk("rst_pcWrite", 10, 32'(pc_write), 32'd1);

    // First edge after release loads a fresh instruction; r5 was cleared.
    @(negedge clk);
    rst_n       = 1'b1;
    ex_mem_read = 1'b0;
    ex_rt       = 5'd0;
    pc_in       = 13'h030;
    instr_in    = 32'h00A63820;
    @(posedge clk);
    #1;
    chk("post_rst_pcOut",   11, 32'(pc_out),   32'h030);
    chk("post_rst_rs",      11, 32'(rs),       32'd5);
    chk("post_rst_rsData",  11, rs_data,       32'd0);
    chk("post_rst_rtData",  11, rt_data,       32'd0);
    chk("post_rst_bubble",  11, 32'(bubble),   32'd0);
    chk("post_rst_pcWrite", 11, 32'(pc_write), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
